// File: rtl/vga_pkg.sv
// Shared types and the region-decode helper for the VGA timing generator.
package vga_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [0:0] {
        WAIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Half-open window test: lo <= cnt < hi.
    function automatic logic in_window(input logic [31:0] cnt,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/vga_counter.sv
// Enabled wrap counter 0..MAX; carry is high in the enabled cycle that wraps.
module vga_counter #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         carry_o
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max_s;

    // Next count and wrap carry
    always_comb begin
        at_max_s = (cnt_q == MAX_C);
        carry_o  = en_i && at_max_s;
        if (!en_i) begin
            cnt_d = cnt_q;
        end else if (at_max_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running counters once started, registered sync/blank/RGB.
// The raster never stalls; an empty FIFO during display yields a black pixel and a sticky flag.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic [23:0] fifo_rdata,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        frame_end,
    output logic        underflow
);

    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);

    state_t        state_q;
    state_t        state_d;
    logic          run_s;
    logic [HW-1:0] hcnt_s;
    logic [VW-1:0] vcnt_s;
    logic          h_carry_s;
    logic          v_carry_s;
    logic          h_disp_s;
    logic          v_disp_s;
    logic          h_pulse_s;
    logic          v_pulse_s;
    logic          active0_s;

    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic blank_q, blank_d;
    logic frame_end_q, frame_end_d;
    logic underflow_q, underflow_d;
    rgb_t rgb_q, rgb_d;

    assign run_s = (state_q == RUN);

    // Vertical counter advances only on the horizontal wrap
    vga_counter #(.MAX(HTOTAL - 1), .W(HW)) u_hcnt (
        .clk_i   (CLK),
        .rst_ni  (NRST),
        .en_i    (run_s),
        .cnt_o   (hcnt_s),
        .carry_o (h_carry_s)
    );

    vga_counter #(.MAX(VTOTAL - 1), .W(VW)) u_vcnt (
        .clk_i   (CLK),
        .rst_ni  (NRST),
        .en_i    (h_carry_s),
        .cnt_o   (vcnt_s),
        .carry_o (v_carry_s)
    );

    // Start on the first available pixel; only reset leaves RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT: begin
                if (!fifo_empty) begin
                    state_d = RUN;
                end else begin
                    state_d = WAIT;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = WAIT;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q <= WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Region decode, pop strobe and next video outputs
    always_comb begin
        h_disp_s    = in_window(32'(hcnt_s), HTOTAL - HDISP, HTOTAL);
        v_disp_s    = in_window(32'(vcnt_s), VTOTAL - VDISP, VTOTAL);
        h_pulse_s   = in_window(32'(hcnt_s), HFP, HFP + HPULSE);
        v_pulse_s   = in_window(32'(vcnt_s), VFP, VFP + VPULSE);
        active0_s   = h_disp_s && v_disp_s;
        fifo_rd     = run_s && active0_s && !fifo_empty;
        hs_d        = !(run_s && h_pulse_s);
        vs_d        = !(run_s && v_pulse_s);
        blank_d     = run_s && active0_s;
        frame_end_d = v_carry_s;
        underflow_d = underflow_q || (blank_d && fifo_empty);
        if (fifo_rd) begin
            rgb_d = fifo_rdata;
        end else begin
            rgb_d = '0;
        end
    end

    // Output stage, one cycle behind the counters
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_q     <= 1'b0;
            rgb_q       <= '0;
            frame_end_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_q     <= blank_d;
            rgb_q       <= rgb_d;
            frame_end_q <= frame_end_d;
            underflow_q <= underflow_d;
        end
    end

    assign VGA_HS    = hs_q;
    assign VGA_VS    = vs_q;
    assign VGA_BLANK = blank_q;
    assign VGA_R     = rgb_q.r;
    assign VGA_G     = rgb_q.g;
    assign VGA_B     = rgb_q.b;
    assign frame_end = frame_end_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: raster-position reference model, start-up vector table,
// per-frame aggregate checks, underflow corners and a mid-frame reset.
module tb_vga_timing_gen;

    localparam int HDISP  = 160;
    localparam int VDISP  = 90;
    localparam int HFP    = 2;
    localparam int HPULSE = 3;
    localparam int HBP    = 3;
    localparam int VFP    = 1;
    localparam int VPULSE = 2;
    localparam int VBP    = 2;
    localparam int HTOTAL = 168;
    localparam int VTOTAL = 95;
    localparam int FRAME  = HTOTAL * VTOTAL;
    localparam int HSTART = HTOTAL - HDISP;
    localparam int VSTART = VTOTAL - VDISP;
    localparam logic [28:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0};

    logic        CLK;
    logic        NRST;
    logic [23:0] fifo_rdata;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        frame_end;
    logic        underflow;

    vga_timing_gen #(
        .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
    ) dut (
        .CLK        (CLK),
        .NRST       (NRST),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK  (VGA_BLANK),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .frame_end  (frame_end),
        .underflow  (underflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: raster position is the number of cycles spent in RUN
    bit m_run = 1'b0;
    int m_t   = 0;
    bit m_uf  = 1'b0;
    bit m_rd  = 1'b0;
    int m_rd_cnt = 0;

    int hs_low, vs_low, blank_hi, rd_hi, fe_cnt;
    int cyc = 0;
    int fe_times[$];
    logic        last_rd;
    logic [23:0] pix;

    typedef struct {
        logic empty;
        logic exp_rd;
        logic exp_hs;
        logic exp_vs;
        logic exp_blank;
        logic exp_uf;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at t=%0d: got %0h expected %0h", name, m_t, got, exp);
        end
    endtask

    function automatic logic [28:0] outs();
        return {VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B, frame_end, underflow};
    endfunction

    task automatic clear_aggr();
        hs_low = 0; vs_low = 0; blank_hi = 0; rd_hi = 0; fe_cnt = 0; m_rd_cnt = 0;
    endtask

    // One clock: drive inputs, check the pop strobe, then check registered outputs after the edge
    task automatic step(input logic empty, input logic [23:0] data);
        int h;
        int v;
        logic act;
        logic e_hs;
        logic e_vs;
        logic e_fe;
        logic [28:0] exp_v;
        fifo_empty = empty;
        fifo_rdata = data;
        #1;
        h    = m_t % HTOTAL;
        v    = (m_t / HTOTAL) % VTOTAL;
        act  = m_run && (h >= HSTART) && (v >= VSTART);
        m_rd = act && !empty;
        last_rd = fifo_rd;
        check("fifo_rd", 32'(fifo_rd), 32'(m_rd));
        if (fifo_rd) rd_hi++;
        if (m_rd) m_rd_cnt++;
        e_hs = !(m_run && h >= HFP && h < HFP + HPULSE);
        e_vs = !(m_run && v >= VFP && v < VFP + VPULSE);
        e_fe = m_run && ((m_t % FRAME) == FRAME - 1);
        if (act && empty) m_uf = 1'b1;
        exp_v = {e_hs, e_vs, act, (m_rd ? data : 24'h000000), e_fe, m_uf};
        if (m_run) begin
            m_t++;
        end else if (!empty) begin
            m_run = 1'b1;
            m_t   = 0;
        end
        @(posedge CLK);
        #1;
        cyc++;
        check("outputs", 32'(outs()), 32'(exp_v));
        if (!VGA_HS) hs_low++;
        if (!VGA_VS) vs_low++;
        if (VGA_BLANK) blank_hi++;
        if (frame_end) begin
            fe_cnt++;
            fe_times.push_back(cyc);
        end
    endtask

    // FWFT FIFO source: the head pixel advances on every pop
    task automatic run_cycle(input logic empty);
        logic [23:0] d;
        d = empty ? 24'($urandom) : pix;
        step(empty, d);
        if (m_rd) pix = pix + 24'd1;
    endtask

    task automatic frame_aggr(input string tag, input int exp_rd);
        check({tag, "_hs_low"}, 32'(hs_low), 32'(HPULSE * VTOTAL));
        check({tag, "_vs_low"}, 32'(vs_low), 32'(VPULSE * HTOTAL));
        check({tag, "_blank_hi"}, 32'(blank_hi), 32'(HDISP * VDISP));
        check({tag, "_rd_cnt"}, 32'(rd_hi), 32'(exp_rd));
        check({tag, "_fe_cnt"}, 32'(fe_cnt), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bit found;
        int p;
        int h;
        int v;

        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        NRST       = 1'b0;
        fifo_empty = 1'b1;
        fifo_rdata = 24'h000000;
        pix        = 24'h000001;
        clear_aggr();
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outs", 32'(outs()), 32'(RESET_VEC));
        check("reset_rd", 32'(fifo_rd), 32'd0);
        NRST = 1'b1;

        // Held in WAIT while the FIFO is empty
        for (int i = 0; i < 50; i++) step(1'b1, 24'($urandom));

        // Start-up: WAIT->RUN, front porch and the HS pulse edges
        clear_aggr();
        for (int i = 0; i < 8; i++) begin
            run_cycle(tbl[i].empty);
            check($sformatf("tbl%0d_rd", i), 32'(last_rd), 32'(tbl[i].exp_rd));
            check($sformatf("tbl%0d_hs", i), 32'(VGA_HS), 32'(tbl[i].exp_hs));
            check($sformatf("tbl%0d_vs", i), 32'(VGA_VS), 32'(tbl[i].exp_vs));
            check($sformatf("tbl%0d_blank", i), 32'(VGA_BLANK), 32'(tbl[i].exp_blank));
            check($sformatf("tbl%0d_uf", i), 32'(underflow), 32'(tbl[i].exp_uf));
        end

        // Frame 1: clean stream with incrementing pixels
        seen = 1'b0;
        while (m_t < FRAME) begin
            run_cycle(1'b0);
            if (!seen && VGA_BLANK) begin
                seen = 1'b1;
                check("first_pix_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h000001);
                check("first_pix_rd_prev", 32'(last_rd), 32'd1);
            end
        end
        check("first_pix_seen", 32'(seen), 32'd1);
        frame_aggr("f1", HDISP * VDISP);
        check("f1_uf_clear", 32'(underflow), 32'd0);

        // Frame 2: underflow corners then random empties
        clear_aggr();
        while (m_t < 2 * FRAME) begin
            p = m_t - FRAME;
            h = p % HTOTAL;
            v = p / HTOTAL;
            if (v == 10 && h == HTOTAL - 1) begin
                run_cycle(1'b1);
                check("lastpix_rd", 32'(last_rd), 32'd0);
                check("lastpix_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h000000);
                check("lastpix_blank", 32'(VGA_BLANK), 32'd1);
                check("lastpix_uf", 32'(underflow), 32'd1);
                run_cycle(1'b0);
                check("lastpix_next_blank", 32'(VGA_BLANK), 32'd0);
            end else if (v == 20 && h == 80) begin
                run_cycle(1'b1);
                check("mid_rd", 32'(last_rd), 32'd0);
                check("mid_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h000000);
                check("mid_blank", 32'(VGA_BLANK), 32'd1);
                check("mid_uf", 32'(underflow), 32'd1);
            end else if (v >= 30) begin
                run_cycle($urandom_range(0, 7) == 0);
            end else begin
                run_cycle(1'b0);
            end
        end
        frame_aggr("f2", m_rd_cnt);
        check("f2_uf_sticky", 32'(underflow), 32'd1);
        check("fe_count", 32'(fe_times.size()), 32'd2);
        if (fe_times.size() >= 2) begin
            check("fe_period", 32'(fe_times[1] - fe_times[0]), 32'(FRAME));
        end

        // Reset asserted mid-frame while video is active
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            run_cycle(1'b0);
            if (VGA_BLANK) found = 1'b1;
        end
        check("midreset_found", 32'(found), 32'd1);
        NRST = 1'b0;
        #2;
        check("midreset_async", 32'(outs()), 32'(RESET_VEC));
        check("midreset_rd", 32'(fifo_rd), 32'd0);
        @(posedge CLK);
        #1;
        check("midreset_held", 32'(outs()), 32'(RESET_VEC));
        NRST  = 1'b1;
        m_run = 1'b0;
        m_t   = 0;
        m_uf  = 1'b0;
        repeat (20) run_cycle(1'b1);
        repeat (HTOTAL * 6) run_cycle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
